// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 800x600@60 raster and the encoding of the
// per-frame game-update handshake FSM.
//   DEF_*           default porch/sync/active sizes and derived totals
//   upd_state_e     IDLE=0, REQ=1, DONE=2
//   in_window()     half-open range test [lo, hi) on full-width values
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FP     = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BP     = 88;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } upd_state_e;

    function automatic logic in_window(input logic [31:0] v,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Fractional clock-enable generator: tick rate = clk * TICK_NUM / TICK_DEN.
//   clk   in  system clock
//   rst   in  synchronous active-high reset (accumulator -> 0)
//   tick  out one-clk enable, high in the cycle where acc+TICK_NUM >= TICK_DEN
module pixel_tick_gen #(
    parameter int TICK_NUM = 2,
    parameter int TICK_DEN = 5
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    // wide enough to hold acc + TICK_NUM without wrapping
    localparam int AW = $clog2(TICK_DEN + TICK_NUM + 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;

    assign acc_sum = acc + AW'(TICK_NUM);
    assign tick    = (acc_sum >= AW'(TICK_DEN));

    always_ff @(posedge clk) begin
        if (rst)       acc <= '0;
        else if (tick) acc <= acc_sum - AW'(TICK_DEN);
        else           acc <= acc_sum;
    end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Display timing owner for the game datapath. Derives the pixel tick, runs the
// raster, fetches colour from the renderer with a one-tick pipeline and
// schedules one game-state update per frame during vertical blank.
//   clk, rst      100 MHz clock, synchronous active-high reset
//   px_x, px_y    raster position being fetched; px_active when visible
//   px_rgb        renderer colour {r,g,b} for px_x/px_y
//   r, g, b       registered colour (0 in blanking); hs, vs aligned syncs
//   pclk_mirror   one-clk strobe, the cycle after r/g/b/hs/vs change
//   upd_req/ack   per-frame update handshake; upd_overrun sticky on timeout
//   frame_cnt     completed frames, wrapping
module vga_frame_sequencer
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b1,
    parameter int   TICK_NUM = 2,
    parameter int   TICK_DEN = 5
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] px_x,
    output logic [9:0]  px_y,
    output logic        px_active,
    input  logic [11:0] px_rgb,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic        pclk_mirror,
    output logic        upd_req,
    input  logic        upd_ack,
    output logic [15:0] frame_cnt,
    output logic        upd_overrun
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic        tick;
    logic [31:0] x_w, y_w;
    logic        x_end, y_end, frame_wrap, vblank_start;
    logic        hs_nxt, vs_nxt;
    logic [1:0]  vld_pipe;
    upd_state_e  state, state_nxt;
    logic        set_overrun;

    pixel_tick_gen #(
        .TICK_NUM (TICK_NUM),
        .TICK_DEN (TICK_DEN)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // all position compares are done at 32 bits against the parameter sums
    assign x_w = 32'(px_x);
    assign y_w = 32'(px_y);

    assign x_end        = (x_w == 32'(H_TOTAL - 1));
    assign y_end        = (y_w == 32'(V_TOTAL - 1));
    assign frame_wrap   = tick && x_end && y_end;
    assign vblank_start = tick && (x_w == 32'd0) && (y_w == 32'(V_ACTIVE));

    assign px_active = (x_w < 32'(H_ACTIVE)) && (y_w < 32'(V_ACTIVE));
    assign hs_nxt    = in_window(x_w, 32'(HS_START), 32'(HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs_nxt    = in_window(y_w, 32'(VS_START), 32'(VS_END)) ? SYNC_POL : ~SYNC_POL;

    // raster
    always_ff @(posedge clk) begin
        if (rst) begin
            px_x <= '0;
            px_y <= '0;
        end else if (tick) begin
            if (x_end) begin
                px_x <= '0;
                px_y <= y_end ? '0 : px_y + 10'd1;
            end else begin
                px_x <= px_x + 11'd1;
            end
        end
    end

    // one-tick output pipeline; the strobe trails the data by one clk so a
    // downstream sampler on its rising edge sees settled r/g/b/hs/vs
    always_ff @(posedge clk) begin
        if (rst) begin
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hs       <= ~SYNC_POL;
            vs       <= ~SYNC_POL;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], tick};
            if (tick) begin
                r  <= px_active ? px_rgb[11:8] : 4'd0;
                g  <= px_active ? px_rgb[7:4]  : 4'd0;
                b  <= px_active ? px_rgb[3:0]  : 4'd0;
                hs <= hs_nxt;
                vs <= vs_nxt;
            end
        end
    end

    assign pclk_mirror = vld_pipe[1];

    always_ff @(posedge clk) begin
        if (rst)             frame_cnt <= '0;
        else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
    end

    // update handshake FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            upd_overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (set_overrun) upd_overrun <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        set_overrun = 1'b0;
        case (state)
            IDLE: if (vblank_start) state_nxt = REQ;
            // ack takes priority over a coincident raster wrap
            REQ: begin
                if (upd_ack) begin
                    state_nxt = DONE;
                end else if (frame_wrap) begin
                    state_nxt   = IDLE;
                    set_overrun = 1'b1;
                end
            end
            DONE: if (frame_wrap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign upd_req = (state == REQ);

endmodule
